// File: rtl/mpdmac_sched_pkg.sv
// Shared types and constants for the MPDMAC job scheduler.
package mpdmac_sched_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned MW_W      = 6;
  localparam int unsigned STAT_W    = 2;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned MIN_WIDTH = 2;

  localparam logic [STAT_W-1:0] ST_OK        = 2'd0;
  localparam logic [STAT_W-1:0] ST_BAD_WIDTH = 2'd1;
  localparam logic [STAT_W-1:0] ST_TIMEOUT   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [MW_W-1:0]   width;
  } sched_job_t;

  // Width is legal when it fits the engine buffer and is at least MIN_WIDTH.
  function automatic logic width_ok(input logic [MW_W-1:0] w, input int unsigned max_w);
    return (32'(w) >= MIN_WIDTH) && (32'(w) <= max_w);
  endfunction

endpackage

// File: rtl/mpdmac_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after rr_ptr wins.
module mpdmac_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  always_comb begin
    int unsigned j;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    j         = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(rr_ptr) + k) % NUM_REQ;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if ((i == j) && !grant_any && req[i]) begin
          grant[i]  = 1'b1;
          grant_idx = IDX_W'(i);
          grant_any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mpdmac_job_sched.sv
// Round-robin job scheduler in front of one MPDMAC padding engine.
// Optional watchdog enabled by defining MPDMAC_SCHED_TIMEOUT_EN.
module mpdmac_job_sched
  import mpdmac_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned MAX_WIDTH   = 32,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*32-1:0] req_src_addr_i,
  input  logic [NUM_REQ*32-1:0] req_dst_addr_i,
  input  logic [NUM_REQ*6-1:0]  req_width_i,
  output logic [31:0]           eng_src_addr_o,
  output logic [31:0]           eng_dst_addr_o,
  output logic [5:0]            eng_mat_width_o,
  output logic                  eng_start_o,
  input  logic                  eng_done_i,
  output logic                  cmpl_valid_o,
  input  logic                  cmpl_ready_i,
  output logic [ID_W-1:0]       cmpl_id_o,
  output logic [1:0]            cmpl_status_o,
  output logic                  busy_o,
  output logic [15:0]           job_cnt_o
);

  if ((NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end
  if ((1 << ID_W) < NUM_REQ) begin : g_bad_id_w
    $error("ID_W too small for NUM_REQ");
  end
  if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 65535)) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..65535");
  end

  sched_state_e      state, state_n;
  logic [ID_W-1:0]   rr_ptr;
  sched_job_t        job_q, job_sel;
  logic [ID_W-1:0]   id_q;
  logic [STAT_W-1:0] status_q;
  logic [CNT_W-1:0]  job_cnt_q;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic               width_good;
  logic               cap_en;
  logic               done_ok;
  logic               tmo_hit;

  mpdmac_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_arb (
    .req       (req_valid_i),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Select the granted requester's job fields.
  always_comb begin
    job_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        job_sel.src   = req_src_addr_i[ADDR_W*i +: ADDR_W];
        job_sel.dst   = req_dst_addr_i[ADDR_W*i +: ADDR_W];
        job_sel.width = req_width_i[MW_W*i +: MW_W];
      end
    end
  end

  assign width_good = width_ok(job_sel.width, MAX_WIDTH);

`ifdef MPDMAC_SCHED_TIMEOUT_EN
  logic [15:0] wdog_q;
  logic        wdog_expired;

  assign wdog_expired = (wdog_q == 16'(TIMEOUT_CYC - 1));

  // Cleared while starting, counts each BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else if (state == START) begin
      wdog_q <= '0;
    end else if (state == BUSY) begin
      wdog_q <= wdog_q + 16'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    req_ready_o = '0;
    cap_en      = 1'b0;
    done_ok     = 1'b0;
    tmo_hit     = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = grant;
        if (grant_any) begin
          cap_en  = 1'b1;
          state_n = width_good ? START : RESP;
        end
      end
      START: state_n = BUSY;
      BUSY: begin
        // A done in the expiry cycle still counts as success.
        if (eng_done_i) begin
          done_ok = 1'b1;
          state_n = RESP;
        end
`ifdef MPDMAC_SCHED_TIMEOUT_EN
        else if (wdog_expired) begin
          tmo_hit = 1'b1;
          state_n = RESP;
        end
`endif
      end
      RESP: begin
        if (cmpl_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Job capture, completion tag and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      job_q    <= '0;
      id_q     <= '0;
      status_q <= ST_OK;
    end else if (cap_en) begin
      rr_ptr   <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      job_q    <= job_sel;
      id_q     <= grant_idx;
      status_q <= width_good ? ST_OK : ST_BAD_WIDTH;
    end else if (done_ok) begin
      status_q <= ST_OK;
    end else if (tmo_hit) begin
      status_q <= ST_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       job_cnt_q <= '0;
    else if (done_ok) job_cnt_q <= job_cnt_q + CNT_W'(1);
  end

  assign eng_src_addr_o  = job_q.src;
  assign eng_dst_addr_o  = job_q.dst;
  assign eng_mat_width_o = job_q.width;
  assign eng_start_o     = (state == START);
  assign busy_o          = (state != IDLE);
  assign cmpl_valid_o    = (state == RESP);
  assign cmpl_id_o       = id_q;
  assign cmpl_status_o   = status_q;
  assign job_cnt_o       = job_cnt_q;

endmodule

// File: tb/tb_mpdmac_job_sched.sv
// Randomized self-checking bench for mpdmac_job_sched with an inline engine model.
module tb_mpdmac_job_sched;

  localparam int NUM_REQ     = 4;
  localparam int ID_W        = 2;
  localparam int MAX_WIDTH   = 32;
  localparam int TIMEOUT_CYC = 100;
  localparam int BUDGET      = 400;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [NUM_REQ*32-1:0] req_src_addr_i;
  logic [NUM_REQ*32-1:0] req_dst_addr_i;
  logic [NUM_REQ*6-1:0]  req_width_i;
  logic [31:0]           eng_src_addr_o;
  logic [31:0]           eng_dst_addr_o;
  logic [5:0]            eng_mat_width_o;
  logic                  eng_start_o;
  logic                  eng_done;
  logic                  cmpl_valid_o;
  logic                  cmpl_ready;
  logic [ID_W-1:0]       cmpl_id_o;
  logic [1:0]            cmpl_status_o;
  logic                  busy_o;
  logic [15:0]           job_cnt_o;

  logic [31:0] rq_src [NUM_REQ];
  logic [31:0] rq_dst [NUM_REQ];
  logic [5:0]  rq_w   [NUM_REQ];

  int errors = 0;
  int checks = 0;
  int m_ptr  = 0;
  int m_cnt  = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_src_addr_i[32*i +: 32] = rq_src[i];
      req_dst_addr_i[32*i +: 32] = rq_dst[i];
      req_width_i[6*i +: 6]      = rq_w[i];
    end
  end

  mpdmac_job_sched #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .MAX_WIDTH(MAX_WIDTH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_src_addr_i(req_src_addr_i), .req_dst_addr_i(req_dst_addr_i), .req_width_i(req_width_i),
    .eng_src_addr_o(eng_src_addr_o), .eng_dst_addr_o(eng_dst_addr_o), .eng_mat_width_o(eng_mat_width_o),
    .eng_start_o(eng_start_o), .eng_done_i(eng_done),
    .cmpl_valid_o(cmpl_valid_o), .cmpl_ready_i(cmpl_ready),
    .cmpl_id_o(cmpl_id_o), .cmpl_status_o(cmpl_status_o),
    .busy_o(busy_o), .job_cnt_o(job_cnt_o)
  );

  // Reference: first valid requester scanning from ptr, wrapping.
  function automatic int pick(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic logic [1:0] exp_status(input int w);
    return (w < 2 || w > MAX_WIDTH) ? 2'd1 : 2'd0;
  endfunction

  task automatic randomize_req(input int i, input int wmin, input int wmax);
    rq_src[i] = $urandom;
    rq_dst[i] = $urandom;
    rq_w[i]   = 6'($urandom_range(wmax, wmin));
  endtask

  // Entered at a negedge in IDLE with requests set; returns at negedge+1 in RESP (or budget out).
  task automatic drive_job(input int lat, output logic [NUM_REQ-1:0] gnt, output int starts,
                           output int t_start, output int t_cmpl, output logic [31:0] o_src,
                           output logic [31:0] o_dst, output logic [5:0] o_w,
                           output logic [ID_W-1:0] o_id, output logic [1:0] o_st, output bit leak);
    bit done_sent;
    starts = 0; t_start = -1; t_cmpl = -1; leak = 0; done_sent = 0;
    o_src = '0; o_dst = '0; o_w = '0; o_id = '0; o_st = '0;
    #1 gnt = req_ready_o;
    if (gnt == '0) return;
    for (int t = 1; t <= BUDGET && t_cmpl < 0; t++) begin
      @(negedge clk);
      eng_done = 1'b0;
      #1;
      if (req_ready_o !== '0) leak = 1;
      if (eng_start_o === 1'b1) begin
        starts++;
        if (t_start < 0) begin
          t_start = t; o_src = eng_src_addr_o; o_dst = eng_dst_addr_o; o_w = eng_mat_width_o;
        end
      end
      if (cmpl_valid_o === 1'b1) begin
        t_cmpl = t; o_id = cmpl_id_o; o_st = cmpl_status_o;
      end else if (t_start >= 0 && !done_sent && t == t_start + lat) begin
        eng_done = 1'b1; done_sent = 1;
      end
    end
  endtask

  task automatic ack();
    cmpl_ready = 1'b1;
    @(negedge clk);
    cmpl_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid_i = '0; eng_done = 1'b0; cmpl_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin rq_src[i] = '0; rq_dst[i] = '0; rq_w[i] = '0; end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (eng_start_o !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", eng_start_o); end
    checks++; if (cmpl_valid_o !== 1'b0) begin errors++; $display("FAIL reset_cmpl_valid: got %b want 0", cmpl_valid_o); end
    checks++; if (req_ready_o !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready_o); end
    checks++; if (job_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_job_cnt: got %0d want 0", job_cnt_o); end
    checks++; if ({eng_src_addr_o, eng_dst_addr_o, eng_mat_width_o, cmpl_id_o, cmpl_status_o} !== '0) begin
      errors++; $display("FAIL reset_regs: got %h want 0", {eng_src_addr_o, eng_dst_addr_o, eng_mat_width_o, cmpl_id_o, cmpl_status_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_ptr = 0; m_cnt = 0;
  endtask

  task automatic test_single_job();
    logic [NUM_REQ-1:0] gnt; int starts, ts, tc; logic [31:0] s, d; logic [5:0] w;
    logic [ID_W-1:0] id; logic [1:0] st; bit leak;
    rq_src[0] = 32'h1000; rq_dst[0] = 32'h2000; rq_w[0] = 6'd4; req_valid_i = 4'b0001;
    drive_job(50, gnt, starts, ts, tc, s, d, w, id, st, leak);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", gnt); end
    checks++; if (starts != 1 || ts != 1) begin errors++; $display("FAIL single_start: got n=%0d t=%0d want n=1 t=1", starts, ts); end
    checks++; if (s !== 32'h1000 || d !== 32'h2000 || w !== 6'd4) begin
      errors++; $display("FAIL single_eng_cfg: got %h/%h/%0d want 1000/2000/4", s, d, w);
    end
    checks++; if (tc != 52) begin errors++; $display("FAIL single_latency: got t=%0d want 52", tc); end
    checks++; if (id !== 2'd0 || st !== 2'd0) begin errors++; $display("FAIL single_cmpl: got id=%0d st=%0d want 0/0", id, st); end
    checks++; if (job_cnt_o !== 16'd1) begin errors++; $display("FAIL single_job_cnt: got %0d want 1", job_cnt_o); end
    checks++; if (eng_src_addr_o !== 32'h1000 || leak) begin
      errors++; $display("FAIL single_stable: got src=%h leak=%0d want 1000/0", eng_src_addr_o, leak);
    end
    m_ptr = 1; m_cnt = 1;
    req_valid_i = '0;
    ack();
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] gnt; int starts, ts, tc, g, lat; logic [31:0] s, d; logic [5:0] w;
    logic [ID_W-1:0] id; logic [1:0] st; bit leak;
    for (int i = 0; i < NUM_REQ; i++) randomize_req(i, 2, MAX_WIDTH);
    req_valid_i = 4'hF;
    for (int j = 0; j < 8; j++) begin
      g = pick(4'hF, m_ptr);
      lat = $urandom_range(6, 1);
      drive_job(lat, gnt, starts, ts, tc, s, d, w, id, st, leak);
      checks++; if (gnt !== 4'(1 << g) || id !== ID_W'(g)) begin
        errors++; $display("FAIL rr_grant[%0d]: got gnt=%b id=%0d want req %0d", j, gnt, id, g);
      end
      checks++; if (starts != 1 || st !== 2'd0 || leak) begin
        errors++; $display("FAIL rr_job[%0d]: got starts=%0d st=%0d leak=%0d want 1/0/0", j, starts, st, leak);
      end
      checks++; if (s !== rq_src[g] || d !== rq_dst[g] || w !== rq_w[g] || tc != ts + lat + 1) begin
        errors++; $display("FAIL rr_cfg[%0d]: got %h/%h/%0d t=%0d want %h/%h/%0d t=%0d",
                           j, s, d, w, tc, rq_src[g], rq_dst[g], rq_w[g], ts + lat + 1);
      end
      m_ptr = (g + 1) % NUM_REQ; m_cnt++;
      randomize_req(g, 2, MAX_WIDTH);
      ack();
    end
    checks++; if (job_cnt_o !== 16'(m_cnt)) begin errors++; $display("FAIL rr_job_cnt: got %0d want %0d", job_cnt_o, m_cnt); end
    req_valid_i = '0;
  endtask

  task automatic test_bad_width();
    int widths[4] = '{1, 33, 2, 32};
    logic [NUM_REQ-1:0] gnt; int starts, ts, tc; logic [31:0] s, d; logic [5:0] w;
    logic [ID_W-1:0] id; logic [1:0] st, est; bit leak;
    foreach (widths[k]) begin
      randomize_req(2, 2, 2);
      rq_w[2] = 6'(widths[k]);
      est = exp_status(widths[k]);
      req_valid_i = 4'b0100;
      drive_job(3, gnt, starts, ts, tc, s, d, w, id, st, leak);
      checks++; if (gnt !== 4'b0100 || id !== 2'd2 || st !== est) begin
        errors++; $display("FAIL bw_cmpl[w=%0d]: got gnt=%b id=%0d st=%0d want 0100/2/%0d", widths[k], gnt, id, st, est);
      end
      checks++; if (est == 2'd1 && (starts != 0 || tc != 1)) begin
        errors++; $display("FAIL bw_nostart[w=%0d]: got starts=%0d t=%0d want 0/1", widths[k], starts, tc);
      end else if (est == 2'd0 && (starts != 1 || tc != ts + 4)) begin
        errors++; $display("FAIL bw_edge_ok[w=%0d]: got starts=%0d t=%0d want 1/%0d", widths[k], starts, tc, ts + 4);
      end
      if (est == 2'd0) m_cnt++;
      checks++; if (job_cnt_o !== 16'(m_cnt)) begin
        errors++; $display("FAIL bw_job_cnt[w=%0d]: got %0d want %0d", widths[k], job_cnt_o, m_cnt);
      end
      m_ptr = 3;
      req_valid_i = '0;
      ack();
    end
  endtask

  task automatic test_backpressure();
    logic [NUM_REQ-1:0] gnt; int starts, ts, tc, g; logic [31:0] s, d; logic [5:0] w;
    logic [ID_W-1:0] id; logic [1:0] st; bit leak;
    for (int i = 0; i < NUM_REQ; i++) randomize_req(i, 2, MAX_WIDTH);
    req_valid_i = 4'hF;
    g = pick(4'hF, m_ptr);
    drive_job(3, gnt, starts, ts, tc, s, d, w, id, st, leak);
    checks++; if (id !== ID_W'(g) || st !== 2'd0) begin errors++; $display("FAIL bp_cmpl: got id=%0d st=%0d want %0d/0", id, st, g); end
    m_ptr = (g + 1) % NUM_REQ; m_cnt++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      checks++; if (cmpl_valid_o !== 1'b1 || cmpl_id_o !== ID_W'(g) || cmpl_status_o !== 2'd0 || req_ready_o !== '0) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d st=%0d rdy=%b want 1/%0d/0/0000",
                           c, cmpl_valid_o, cmpl_id_o, cmpl_status_o, req_ready_o, g);
      end
    end
    ack();
    g = pick(4'hF, m_ptr);
    drive_job(2, gnt, starts, ts, tc, s, d, w, id, st, leak);
    checks++; if (gnt !== 4'(1 << g) || st !== 2'd0) begin
      errors++; $display("FAIL bp_next_grant: got gnt=%b st=%0d want req %0d st 0", gnt, st, g);
    end
    m_ptr = (g + 1) % NUM_REQ; m_cnt++;
    req_valid_i = '0;
    ack();
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] gnt, mask; int starts, ts, tc, g, lat; logic [31:0] s, d; logic [5:0] w;
    logic [ID_W-1:0] id; logic [1:0] st, est; bit leak;
    for (int j = 0; j < 24; j++) begin
      if ($urandom_range(3, 0) == 0) begin
        // idle cycle with a stray done pulse, which must be ignored
        req_valid_i = '0; eng_done = 1'b1;
        #1;
        checks++; if (req_ready_o !== '0) begin errors++; $display("FAIL rnd_idle_ready[%0d]: got %b want 0", j, req_ready_o); end
        @(negedge clk); eng_done = 1'b0; #1;
        checks++; if (busy_o !== 1'b0 || cmpl_valid_o !== 1'b0 || job_cnt_o !== 16'(m_cnt)) begin
          errors++; $display("FAIL rnd_stray_done[%0d]: got busy=%b v=%b cnt=%0d want 0/0/%0d", j, busy_o, cmpl_valid_o, job_cnt_o, m_cnt);
        end
        @(negedge clk);
      end
      for (int i = 0; i < NUM_REQ; i++) randomize_req(i, 0, 63);
      mask = 4'($urandom_range(15, 1));
      req_valid_i = mask;
      g = pick(mask, m_ptr);
      est = exp_status(int'(rq_w[g]));
      lat = $urandom_range(8, 1);
      drive_job(lat, gnt, starts, ts, tc, s, d, w, id, st, leak);
      checks++; if (gnt !== 4'(1 << g) || id !== ID_W'(g) || st !== est || leak) begin
        errors++; $display("FAIL rnd_cmpl[%0d]: got gnt=%b id=%0d st=%0d leak=%0d want req %0d st %0d",
                           j, gnt, id, st, leak, g, est);
      end
      if (est == 2'd0) begin
        checks++; if (starts != 1 || tc != ts + lat + 1 || s !== rq_src[g] || w !== rq_w[g]) begin
          errors++; $display("FAIL rnd_ok_path[%0d]: got starts=%0d t=%0d src=%h w=%0d want 1/%0d/%h/%0d",
                             j, starts, tc, s, w, ts + lat + 1, rq_src[g], rq_w[g]);
        end
        m_cnt++;
      end else begin
        checks++; if (starts != 0 || tc != 1) begin
          errors++; $display("FAIL rnd_bad_path[%0d]: got starts=%0d t=%0d want 0/1", j, starts, tc);
        end
      end
      m_ptr = (g + 1) % NUM_REQ;
      req_valid_i = 4'($urandom_range(15, 0));
      repeat ($urandom_range(3, 0)) @(negedge clk);
      req_valid_i = '0;
      ack();
    end
    checks++; if (job_cnt_o !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_job_cnt: got %0d want %0d", job_cnt_o, m_cnt); end
  endtask

  task automatic test_async_reset();
    logic [NUM_REQ-1:0] gnt; int starts, ts, tc; logic [31:0] s, d; logic [5:0] w;
    logic [ID_W-1:0] id; logic [1:0] st; bit leak;
    randomize_req(0, 4, 16);
    req_valid_i = 4'b0001;
    @(negedge clk);
    req_valid_i = '0;
    repeat (4) @(negedge clk);
    #2;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL ar_pre_busy: got %b want 1", busy_o); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy_o, eng_start_o, cmpl_valid_o, req_ready_o, job_cnt_o} !== '0) begin
      errors++; $display("FAIL ar_outputs: got busy=%b start=%b v=%b rdy=%b cnt=%0d want all 0",
                         busy_o, eng_start_o, cmpl_valid_o, req_ready_o, job_cnt_o);
    end
    checks++; if ({eng_src_addr_o, eng_dst_addr_o, eng_mat_width_o, cmpl_id_o, cmpl_status_o} !== '0) begin
      errors++; $display("FAIL ar_regs: got %h want 0", {eng_src_addr_o, eng_dst_addr_o, eng_mat_width_o, cmpl_id_o, cmpl_status_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_ptr = 0; m_cnt = 0;
    for (int i = 0; i < NUM_REQ; i++) randomize_req(i, 2, MAX_WIDTH);
    req_valid_i = 4'hF;
    drive_job(2, gnt, starts, ts, tc, s, d, w, id, st, leak);
    checks++; if (gnt !== 4'b0001 || id !== 2'd0 || st !== 2'd0) begin
      errors++; $display("FAIL ar_first_grant: got gnt=%b id=%0d st=%0d want 0001/0/0", gnt, id, st);
    end
    m_ptr = 1; m_cnt = 1;
    req_valid_i = '0;
    ack();
    checks++; if (job_cnt_o !== 16'd1) begin errors++; $display("FAIL ar_job_cnt: got %0d want 1", job_cnt_o); end
  endtask

`ifdef MPDMAC_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    logic [NUM_REQ-1:0] gnt; int starts, ts, tc; logic [31:0] s, d; logic [5:0] w;
    logic [ID_W-1:0] id; logic [1:0] st; bit leak;
    // done on the very cycle the watchdog expires
    randomize_req(0, 2, MAX_WIDTH);
    req_valid_i = 4'b0001;
    drive_job(TIMEOUT_CYC, gnt, starts, ts, tc, s, d, w, id, st, leak);
    m_cnt++;
    checks++; if (st !== 2'd0 || tc != ts + TIMEOUT_CYC + 1 || job_cnt_o !== 16'(m_cnt)) begin
      errors++; $display("FAIL to_tie: got st=%0d t=%0d cnt=%0d want 0/%0d/%0d", st, tc, job_cnt_o, ts + TIMEOUT_CYC + 1, m_cnt);
    end
    req_valid_i = '0;
    ack();
    // engine never answers
    randomize_req(0, 2, MAX_WIDTH);
    req_valid_i = 4'b0001;
    drive_job(10000, gnt, starts, ts, tc, s, d, w, id, st, leak);
    checks++; if (st !== 2'd2 || id !== 2'd0 || tc != ts + TIMEOUT_CYC + 1) begin
      errors++; $display("FAIL to_expire: got st=%0d id=%0d t=%0d want 2/0/%0d", st, id, tc, ts + TIMEOUT_CYC + 1);
    end
    checks++; if (job_cnt_o !== 16'(m_cnt)) begin errors++; $display("FAIL to_job_cnt: got %0d want %0d", job_cnt_o, m_cnt); end
    req_valid_i = '0;
    ack();
    repeat (150 - tc - 1) @(negedge clk);
    eng_done = 1'b1;
    @(negedge clk); eng_done = 1'b0; #1;
    checks++; if (cmpl_valid_o !== 1'b0 || busy_o !== 1'b0 || job_cnt_o !== 16'(m_cnt)) begin
      errors++; $display("FAIL to_late_done: got v=%b busy=%b cnt=%0d want 0/0/%0d", cmpl_valid_o, busy_o, job_cnt_o, m_cnt);
    end
    m_ptr = 1;
  endtask
`endif

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_bad_width();
    test_backpressure();
    test_random();
    test_async_reset();
`ifdef MPDMAC_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mpdmac_job_sched.md
Name: mpdmac_job_sched

Overview:
- Round-robin scheduler that shares one MPDMAC padding engine between NUM_REQ requesters (CPU config path, accelerator queues).
- Accepts one job at a time per requester as a valid/ready handshake carrying src, dst and width.
- Range-checks the width, drives the engine's config and start, waits for engine done, then returns a tagged completion.
- Sits between the requesters and the engine's config/start/done interface; the engine's AXI traffic does not pass through this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, completion id width; must satisfy 2**ID_W >= NUM_REQ.
- MAX_WIDTH, 32, largest legal matrix width (engine buffer is 32x32).
- TIMEOUT_CYC, 65535, watchdog limit in cycles; used only with MPDMAC_SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- req_valid_i  in  NUM_REQ  per-requester job valid.
- req_ready_o  out  NUM_REQ  per-requester accept; at most one bit set.
- req_src_addr_i  in  NUM_REQ*32  packed source addresses; requester i at [32i+31:32i].
- req_dst_addr_i  in  NUM_REQ*32  packed destination addresses.
- req_width_i  in  NUM_REQ*6  packed matrix widths N.
- eng_src_addr_o  out  32  engine source address.
- eng_dst_addr_o  out  32  engine destination address.
- eng_mat_width_o  out  6  engine matrix width.
- eng_start_o  out  1  one-cycle start pulse to the engine.
- eng_done_i  in  1  one-cycle done pulse from the engine.
- cmpl_valid_o  out  1  completion valid.
- cmpl_ready_i  in  1  completion accept.
- cmpl_id_o  out  ID_W  index of the requester that owns the completion.
- cmpl_status_o  out  2  completion status: 0 OK, 1 BAD_WIDTH, 2 TIMEOUT.
- busy_o  out  1  high whenever state != IDLE.
- job_cnt_o  out  16  count of jobs completed with status OK; wraps.

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low, applied to every flop.
- Reset values: all outputs 0; state = IDLE; rr_ptr = 0; job_cnt = 0.
- State machine: IDLE, START, BUSY, RESP.
- IDLE:
  - Grant g is the first index with req_valid_i set, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready_o[g] = 1, combinational from req_valid_i and rr_ptr; all other ready bits 0. No grant when no valid.
  - On handshake, register src, dst, width and id = g, and set rr_ptr = (g+1) mod NUM_REQ.
  - If width < 2 or width > MAX_WIDTH: go to RESP with status 1 and do not start the engine.
  - Otherwise go to START.
- START:
  - eng_start_o = 1 for exactly this one cycle, then go to BUSY.
  - eng_*_o are driven from the captured registers and stay stable from START until the next job capture.
- BUSY:
  - Wait for eng_done_i; on it, go to RESP with status 0 and increment job_cnt.
  - eng_done_i is sampled only in BUSY; a pulse in any other state is ignored.
- RESP:
  - cmpl_valid_o = 1, with id and status held stable until cmpl_ready_i.
  - On handshake, go to IDLE. The next grant is possible in that IDLE cycle.
- Latency: capture at cycle T, eng_start_o at T+1, eng_done_i at D, cmpl_valid_o at D+1.
  - Minimum turnaround between consecutive jobs: 1 IDLE cycle.
  - BAD_WIDTH jobs: cmpl_valid_o at T+1.
- Fairness: requester i waits at most NUM_REQ-1 jobs ahead of it. A requester deasserting valid before its grant is legal and loses its turn.
- Simultaneous events: cmpl_ready_i held high gives a 1-cycle RESP. A new req_valid_i during START/BUSY/RESP is not accepted (all ready bits 0).
- Reset mid-job: the block returns to IDLE immediately. The engine has its own reset and must be reset together with this block.

Optional Feature:
- MPDMAC_SCHED_TIMEOUT_EN defined:
  - A 16-bit watchdog clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYC without eng_done_i: go to RESP with status 2; job_cnt is not incremented.
  - A late eng_done_i after timeout is ignored.
  - If eng_done_i and expiry occur in the same cycle, done wins (status 0).
- Not defined: no watchdog and no counter logic; status 2 is never produced and BUSY waits indefinitely.

Decomposition:
- Package mpdmac_sched_pkg holds:
  - state enum: IDLE, START, BUSY, RESP;
  - status localparams: ST_OK=0, ST_BAD_WIDTH=1, ST_TIMEOUT=2;
  - MIN_WIDTH = 2.
- One sub-module, mpdmac_rr_arbiter: parameterised NUM_REQ, inputs req and rr_ptr, outputs one-hot grant plus encoded index. Purely combinational; rr_ptr stays in the parent.

Test Plan:
- Single job: requester 0 with src=0x1000, dst=0x2000, width=4; engine model pulses done 50 cycles after start → eng_start_o one cycle at T+1, eng_*_o = 0x1000/0x2000/4, completion id=0, status=0, job_cnt=1.
- All 4 requesters valid continuously, 8 jobs → grant order 0,1,2,3,0,1,2,3; exactly one eng_start_o per job.
- Width=1 and width=33 on requester 2 → no eng_start_o; completion id=2, status=1 at T+1; job_cnt unchanged.
- cmpl_ready_i held low 10 cycles → cmpl_valid_o, id and status stable; all req_ready_o = 0; next grant only after the completion handshake.
- Reset asserted asynchronously mid-BUSY → all outputs 0 without a clock edge; after release, rr_ptr=0 and requester 0 is granted first.
- With MPDMAC_SCHED_TIMEOUT_EN and TIMEOUT_CYC=100, engine never signals done → status 2 100 cycles after BUSY entry; a done pulse at cycle 150 is ignored.
